pipeline_hazard_ctrl: RTL and testbench

- Central hazard and sequencing controller for the 5-stage VeSPA CPU pipeline.
- Drives stall and flush controls for the PC and the four pipeline registers: IF/ID, ID/EX, EX/MEM and MEM/WB.
- Resolves data-memory wait states, taken-branch squashes, load-use hazards and HLT drain/halt.
- Keeps a registered stall-cycle counter and a memory-timeout flag for debug.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 13 +
 rtl/pipeline_hazard_ctrl_load_use_detect.sv | 27 ++
 rtl/pipeline_hazard_ctrl.sv | 156 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared state encodings and constants for the VeSPA pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        HZ_RUN     = 2'd0,
        HZ_MEMWAIT = 2'd1,
        HZ_DRAIN   = 2'd2,
        HZ_HALTED  = 2'd3
    } hz_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use comparator: a load in EX feeds a source register read in ID.
module pipeline_hazard_ctrl_load_use_detect
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter bit R0_IS_ZERO = 1'b1
) (
    input  logic       i_ExIsLoad,
    input  logic       i_ExWrEnRf,
    input  logic [4:0] i_ExRdst,
    input  logic [4:0] i_IdRs1,
    input  logic [4:0] i_IdRs2,
    input  logic       i_IdUsesRs1,
    input  logic       i_IdUsesRs2,
    output logic       o_LoadUse
);

    logic w_DstLive;
    logic w_Rs1Hit;
    logic w_Rs2Hit;

    // A hard-wired zero register can never carry a pending load result.
    assign w_DstLive = (i_ExRdst != REG_ZERO) || !R0_IS_ZERO;
    assign w_Rs1Hit  = i_IdUsesRs1 && (i_IdRs1 == i_ExRdst);
    assign w_Rs2Hit  = i_IdUsesRs2 && (i_IdRs2 == i_ExRdst);
    assign o_LoadUse = i_ExIsLoad && i_ExWrEnRf && w_DstLive && (w_Rs1Hit || w_Rs2Hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencing for the 5-stage VeSPA pipeline: memory waits, branch
// squashes, load-use bubbles and HLT drain, plus debug stall/timeout counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT  = 255,
    parameter int DRAIN_CYCLES = 3,
    parameter bit R0_IS_ZERO   = 1'b1
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic [4:0]  i_IdRs1,
    input  logic [4:0]  i_IdRs2,
    input  logic        i_IdUsesRs1,
    input  logic        i_IdUsesRs2,
    input  logic        i_IdHalt,
    input  logic        i_ExIsLoad,
    input  logic        i_ExWrEnRf,
    input  logic [4:0]  i_ExRdst,
    input  logic        i_ExBranchTaken,
    input  logic        i_MemReq,
    input  logic        i_MemReady,
    output logic        o_StallPc,
    output logic        o_StallIfId,
    output logic        o_StallIdEx,
    output logic        o_StallExMem,
    output logic        o_StallMemWb,
    output logic        o_FlushIfId,
    output logic        o_FlushIdEx,
    output logic        o_Halted,
    output logic        o_MemTimeout,
    output logic [31:0] o_StallCount
);

    localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);
    localparam logic [7:0] DRAIN_LAST  = 8'(DRAIN_CYCLES - 1);

    hz_state_e   r_State;
    logic [7:0]  r_WaitCnt;
    logic [7:0]  r_DrainCnt;
    logic        r_Halted;
    logic        r_MemTimeout;
    logic [31:0] r_StallCount;

    logic        w_LoadUse;
    logic        w_MemWait;
    logic        w_Draining;
    logic [7:0]  w_WaitNext;

    pipeline_hazard_ctrl_load_use_detect #(
        .R0_IS_ZERO (R0_IS_ZERO)
    ) u_load_use (
        .i_ExIsLoad  (i_ExIsLoad),
        .i_ExWrEnRf  (i_ExWrEnRf),
        .i_ExRdst    (i_ExRdst),
        .i_IdRs1     (i_IdRs1),
        .i_IdRs2     (i_IdRs2),
        .i_IdUsesRs1 (i_IdUsesRs1),
        .i_IdUsesRs2 (i_IdUsesRs2),
        .o_LoadUse   (w_LoadUse)
    );

    // Once halted the core ignores memory entirely; only reset leaves HALTED.
    assign w_MemWait  = i_MemReq && !i_MemReady && (r_State != HZ_HALTED);
    assign w_Draining = (r_State == HZ_DRAIN) || (r_State == HZ_HALTED);
    assign w_WaitNext = (r_WaitCnt == 8'hFF) ? r_WaitCnt : r_WaitCnt + 8'd1;

    always_comb begin
        o_StallPc    = 1'b0;
        o_StallIfId  = 1'b0;
        o_StallIdEx  = 1'b0;
        o_StallExMem = 1'b0;
        o_StallMemWb = 1'b0;
        o_FlushIfId  = 1'b0;
        o_FlushIdEx  = 1'b0;
        if (!i_Rst) begin
            if (w_MemWait) begin
                o_StallPc    = 1'b1;
                o_StallIfId  = 1'b1;
                o_StallIdEx  = 1'b1;
                o_StallExMem = 1'b1;
                o_StallMemWb = 1'b1;
            end else if (w_Draining) begin
                o_StallPc    = 1'b1;
                o_StallIfId  = 1'b1;
                o_FlushIdEx  = 1'b1;
            end else if (i_ExBranchTaken) begin
                o_FlushIfId  = 1'b1;
                o_FlushIdEx  = 1'b1;
            end else if (w_LoadUse) begin
                o_StallPc    = 1'b1;
                o_StallIfId  = 1'b1;
                o_FlushIdEx  = 1'b1;
            end else if (i_IdHalt) begin
                o_StallPc    = 1'b1;
                o_StallIfId  = 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_State      <= HZ_RUN;
            r_WaitCnt    <= 8'd0;
            r_DrainCnt   <= 8'd0;
            r_Halted     <= 1'b0;
            r_MemTimeout <= 1'b0;
            r_StallCount <= 32'd0;
        end else begin
            if (o_StallPc) begin
                r_StallCount <= r_StallCount + 32'd1;
            end
            case (r_State)
                HZ_RUN, HZ_MEMWAIT: begin
                    if (w_MemWait) begin
                        r_State   <= HZ_MEMWAIT;
                        r_WaitCnt <= w_WaitNext;
                        if (w_WaitNext >= TIMEOUT_LIM) begin
                            r_MemTimeout <= 1'b1;
                        end
                    end else begin
                        r_WaitCnt <= 8'd0;
                        // HLT only takes effect when it is not being squashed or re-issued.
                        if (i_IdHalt && !i_ExBranchTaken && !w_LoadUse) begin
                            r_State    <= HZ_DRAIN;
                            r_DrainCnt <= 8'd0;
                        end else begin
                            r_State <= HZ_RUN;
                        end
                    end
                end
                HZ_DRAIN: begin
                    if (!w_MemWait) begin
                        if (r_DrainCnt == DRAIN_LAST) begin
                            r_State  <= HZ_HALTED;
                            r_Halted <= 1'b1;
                        end else begin
                            r_DrainCnt <= r_DrainCnt + 8'd1;
                        end
                    end
                end
                HZ_HALTED: begin
                    r_State <= HZ_HALTED;
                end
                default: begin
                    r_State <= HZ_RUN;
                end
            endcase
        end
    end

    assign o_Halted     = r_Halted;
    assign o_MemTimeout = r_MemTimeout;
    assign o_StallCount = r_StallCount;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed per-cycle vectors with
// hand-computed stall/flush, halt, timeout and stall-count expectations.
module tb_pipeline_hazard_ctrl;

    logic        clk;
    logic        i_Rst;
    logic [4:0]  i_IdRs1;
    logic [4:0]  i_IdRs2;
    logic        i_IdUsesRs1;
    logic        i_IdUsesRs2;
    logic        i_IdHalt;
    logic        i_ExIsLoad;
    logic        i_ExWrEnRf;
    logic [4:0]  i_ExRdst;
    logic        i_ExBranchTaken;
    logic        i_MemReq;
    logic        i_MemReady;
    logic        o_StallPc;
    logic        o_StallIfId;
    logic        o_StallIdEx;
    logic        o_StallExMem;
    logic        o_StallMemWb;
    logic        o_FlushIfId;
    logic        o_FlushIdEx;
    logic        o_Halted;
    logic        o_MemTimeout;
    logic [31:0] o_StallCount;

    typedef struct {
        string       nm;
        logic [6:0]  sf;
        logic        h;
        logic        t;
        logic [31:0] c;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // sf = {StallPc, StallIfId, StallIdEx, StallExMem, StallMemWb, FlushIfId, FlushIdEx}
    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] ALL  = 7'b1111100;
    localparam logic [6:0] BR   = 7'b0000011;
    localparam logic [6:0] LU   = 7'b1100001;
    localparam logic [6:0] HS   = 7'b1100000;
    localparam logic [6:0] DR   = 7'b1100001;

    // c = {IdHalt, ExBranchTaken, ExIsLoad, ExWrEnRf, IdUsesRs1, IdUsesRs2, MemReq, MemReady}
    localparam logic [7:0] IDLE  = 8'b00000000;
    localparam logic [7:0] MWAIT = 8'b00000010;
    localparam logic [7:0] MRDY  = 8'b00000011;

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT  (3),
        .DRAIN_CYCLES (3),
        .R0_IS_ZERO   (1'b1)
    ) dut (
        .i_Clk           (clk),
        .i_Rst           (i_Rst),
        .i_IdRs1         (i_IdRs1),
        .i_IdRs2         (i_IdRs2),
        .i_IdUsesRs1     (i_IdUsesRs1),
        .i_IdUsesRs2     (i_IdUsesRs2),
        .i_IdHalt        (i_IdHalt),
        .i_ExIsLoad      (i_ExIsLoad),
        .i_ExWrEnRf      (i_ExWrEnRf),
        .i_ExRdst        (i_ExRdst),
        .i_ExBranchTaken (i_ExBranchTaken),
        .i_MemReq        (i_MemReq),
        .i_MemReady      (i_MemReady),
        .o_StallPc       (o_StallPc),
        .o_StallIfId     (o_StallIfId),
        .o_StallIdEx     (o_StallIdEx),
        .o_StallExMem    (o_StallExMem),
        .o_StallMemWb    (o_StallMemWb),
        .o_FlushIfId     (o_FlushIfId),
        .o_FlushIdEx     (o_FlushIdEx),
        .o_Halted        (o_Halted),
        .o_MemTimeout    (o_MemTimeout),
        .o_StallCount    (o_StallCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc(input string nm, input logic rst, input logic [7:0] c,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [6:0] esf, input logic eh, input logic et,
                       input logic [31:0] ec);
        exp_t e;
        @(posedge clk);
        #1;
        i_Rst = rst;
        {i_IdHalt, i_ExBranchTaken, i_ExIsLoad, i_ExWrEnRf,
         i_IdUsesRs1, i_IdUsesRs2, i_MemReq, i_MemReady} = c;
        i_ExRdst = rd;
        i_IdRs1  = rs1;
        i_IdRs2  = rs2;
        e.nm = nm;
        e.sf = esf;
        e.h  = eh;
        e.t  = et;
        e.c  = ec;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t        e;
        logic [40:0] act;
        logic [40:0] expv;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e    = sb.pop_front();
                act  = {o_StallPc, o_StallIfId, o_StallIdEx, o_StallExMem, o_StallMemWb,
                        o_FlushIfId, o_FlushIdEx, o_Halted, o_MemTimeout, o_StallCount};
                expv = {e.sf, e.h, e.t, e.c};
                n_chk++;
                if (act !== expv) begin
                    n_fail++;
                    $display("FAIL %s: got sf=%b halted=%b tmo=%b cnt=%0d, expected sf=%b halted=%b tmo=%b cnt=%0d",
                             e.nm, act[40:34], act[33], act[32], act[31:0],
                             e.sf, e.h, e.t, e.c);
                end
            end
        end
    end

    initial begin : stim
        i_Rst = 1'b1;
        {i_IdHalt, i_ExBranchTaken, i_ExIsLoad, i_ExWrEnRf,
         i_IdUsesRs1, i_IdUsesRs2, i_MemReq, i_MemReady} = IDLE;
        i_ExRdst = 5'd0;
        i_IdRs1  = 5'd0;
        i_IdRs2  = 5'd0;

        cyc("rst_gate_memwait", 1'b1, MWAIT, 5'd0, 5'd0, 5'd0, NONE, 1'b0, 1'b0, 32'd0);
        cyc("rst_hold",         1'b1, IDLE,  5'd0, 5'd0, 5'd0, NONE, 1'b0, 1'b0, 32'd0);
        cyc("reset_state",      1'b0, IDLE,  5'd0, 5'd0, 5'd0, NONE, 1'b0, 1'b0, 32'd0);

        cyc("lu_rs2_hit",       1'b0, 8'b00110100, 5'd5, 5'd0, 5'd5, LU,   1'b0, 1'b0, 32'd0);
        cyc("lu_one_cycle",     1'b0, IDLE,        5'd0, 5'd0, 5'd0, NONE, 1'b0, 1'b0, 32'd1);
        cyc("lu_r0_ignored",    1'b0, 8'b00110100, 5'd0, 5'd0, 5'd0, NONE, 1'b0, 1'b0, 32'd1);
        cyc("lu_rs1_hit",       1'b0, 8'b00111000, 5'd7, 5'd7, 5'd0, LU,   1'b0, 1'b0, 32'd1);
        cyc("lu_rs1_unused",    1'b0, 8'b00110000, 5'd7, 5'd7, 5'd0, NONE, 1'b0, 1'b0, 32'd2);
        cyc("lu_not_load",      1'b0, 8'b00011000, 5'd7, 5'd7, 5'd0, NONE, 1'b0, 1'b0, 32'd2);
        cyc("branch_over_lu",   1'b0, 8'b01110100, 5'd5, 5'd0, 5'd5, BR,   1'b0, 1'b0, 32'd2);
        cyc("branch_over_hlt",  1'b0, 8'b11000000, 5'd0, 5'd0, 5'd0, BR,   1'b0, 1'b0, 32'd2);
        cyc("hlt_squashed",     1'b0, IDLE,        5'd0, 5'd0, 5'd0, NONE, 1'b0, 1'b0, 32'd2);

        cyc("memwait_1",        1'b0, MWAIT,       5'd0, 5'd0, 5'd0, ALL,  1'b0, 1'b0, 32'd2);
        cyc("memwait_2",        1'b0, MWAIT,       5'd0, 5'd0, 5'd0, ALL,  1'b0, 1'b0, 32'd3);
        cyc("memwait_3",        1'b0, MWAIT,       5'd0, 5'd0, 5'd0, ALL,  1'b0, 1'b0, 32'd4);
        cyc("memwait_4_over_br",1'b0, 8'b01000010, 5'd0, 5'd0, 5'd0, ALL,  1'b0, 1'b1, 32'd5);
        cyc("mem_ready",        1'b0, MRDY,        5'd0, 5'd0, 5'd0, NONE, 1'b0, 1'b1, 32'd6);
        cyc("tmo_sticky",       1'b0, IDLE,        5'd0, 5'd0, 5'd0, NONE, 1'b0, 1'b1, 32'd6);
        cyc("run_after_wait",   1'b0, 8'b00110100, 5'd5, 5'd0, 5'd5, LU,   1'b0, 1'b1, 32'd6);
        cyc("idle_a",           1'b0, IDLE,        5'd0, 5'd0, 5'd0, NONE, 1'b0, 1'b1, 32'd7);

        cyc("memwait_b1",       1'b0, MWAIT,       5'd0, 5'd0, 5'd0, ALL,  1'b0, 1'b1, 32'd7);
        cyc("memwait_b2",       1'b0, MWAIT,       5'd0, 5'd0, 5'd0, ALL,  1'b0, 1'b1, 32'd8);
        cyc("rst_in_memwait",   1'b1, MWAIT,       5'd0, 5'd0, 5'd0, NONE, 1'b0, 1'b1, 32'd9);
        cyc("after_rst_wait",   1'b0, IDLE,        5'd0, 5'd0, 5'd0, NONE, 1'b0, 1'b0, 32'd0);

        cyc("wait_c1",          1'b0, MWAIT,       5'd0, 5'd0, 5'd0, ALL,  1'b0, 1'b0, 32'd0);
        cyc("wait_c2",          1'b0, MWAIT,       5'd0, 5'd0, 5'd0, ALL,  1'b0, 1'b0, 32'd1);
        cyc("ready_c",          1'b0, MRDY,        5'd0, 5'd0, 5'd0, NONE, 1'b0, 1'b0, 32'd2);
        cyc("wait_d1",          1'b0, MWAIT,       5'd0, 5'd0, 5'd0, ALL,  1'b0, 1'b0, 32'd2);
        cyc("wait_d2_cleared",  1'b0, MWAIT,       5'd0, 5'd0, 5'd0, ALL,  1'b0, 1'b0, 32'd3);
        cyc("wait_d_exit",      1'b0, IDLE,        5'd0, 5'd0, 5'd0, NONE, 1'b0, 1'b0, 32'd4);

        cyc("hlt_in_id",        1'b0, 8'b10000000, 5'd0, 5'd0, 5'd0, HS,   1'b0, 1'b0, 32'd4);
        cyc("drain_0",          1'b0, IDLE,        5'd0, 5'd0, 5'd0, DR,   1'b0, 1'b0, 32'd5);
        cyc("drain_memwait",    1'b0, MWAIT,       5'd0, 5'd0, 5'd0, ALL,  1'b0, 1'b0, 32'd6);
        cyc("drain_1",          1'b0, IDLE,        5'd0, 5'd0, 5'd0, DR,   1'b0, 1'b0, 32'd7);
        cyc("drain_2",          1'b0, IDLE,        5'd0, 5'd0, 5'd0, DR,   1'b0, 1'b0, 32'd8);
        cyc("halted_ignore_br", 1'b0, 8'b01000010, 5'd0, 5'd0, 5'd0, DR,   1'b1, 1'b0, 32'd9);
        cyc("halted_ignore_lu", 1'b0, 8'b00110100, 5'd5, 5'd0, 5'd5, DR,   1'b1, 1'b0, 32'd10);
        cyc("rst_in_halted",    1'b1, IDLE,        5'd0, 5'd0, 5'd0, NONE, 1'b1, 1'b0, 32'd11);
        cyc("halt_cleared",     1'b0, IDLE,        5'd0, 5'd0, 5'd0, NONE, 1'b0, 1'b0, 32'd0);

        repeat (4) @(negedge clk);
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_scoreboard: got %0d pending entries, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
